// File: rtl/stream_mux_n.sv
// stream_mux_n -- N-input, WIDTH-bit stream multiplexer with valid/ready on
// every channel and a single registered output stage.
//
// Channel selection:
//   mode=0 : external select, channel 'sel' only (out-of-range sel -> no grant)
//   mode=1 : round-robin among valid inputs, scanning upward from last_grant+1
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode, sel           selection mode and external channel index
//   in_valid/in_data    per-channel stream inputs (channel i at [i*WIDTH +: WIDTH])
//   in_ready            per-channel ready, at most one bit set
//   out_valid/out_data  registered output word
//   out_ready           consumer accept
//   out_chan            (only with STREAM_MUX_N_CHAN_TAG_EN) index of the
//                       channel that supplied out_data
//
// Optional feature macro: STREAM_MUX_N_CHAN_TAG_EN

// Per-channel slice: ready gating and zero-masked data for the OR-reduction mux.
module stream_mux_n_lane #(
  parameter int WIDTH = 4
) (
  input  logic             grant,
  input  logic             can_load,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_sel
);
  // Ready is forced low while in reset so no handshake completes in that cycle.
  assign ready    = grant & can_load & ~rst;
  assign data_sel = grant ? data : '0;
endmodule

module stream_mux_n #(
  parameter  int N_INPUTS = 4,
  parameter  int WIDTH    = 4,
  localparam int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [N_INPUTS-1:0]       in_valid,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  output logic [N_INPUTS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready
`ifdef STREAM_MUX_N_CHAN_TAG_EN
  ,
  output logic [SEL_W-1:0]          out_chan
`endif
);

  localparam logic [SEL_W:0] NV = (SEL_W+1)'(N_INPUTS);

  logic [SEL_W-1:0]                last_grant;
  logic                            can_load;
  logic                            ghit;
  logic [SEL_W-1:0]                gidx;
  logic [SEL_W:0]                  scan;
  logic [N_INPUTS-1:0]             grant;
  logic [N_INPUTS-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]                mux_data;
  logic                            xfer;

  assign can_load = !out_valid || out_ready;

  // Grant index. The round-robin scan uses one extra bit so the wrap past
  // N_INPUTS-1 works for non-power-of-two channel counts.
  always_comb begin
    ghit = 1'b0;
    gidx = '0;
    scan = '0;
    if (!mode) begin
      if ({1'b0, sel} < NV) begin
        ghit = in_valid[sel];
        gidx = sel;
      end
    end else begin
      for (int k = 1; k <= N_INPUTS; k++) begin
        scan = {1'b0, last_grant} + (SEL_W+1)'(k);
        if (scan >= NV) scan = scan - NV;
        if (!ghit && in_valid[scan[SEL_W-1:0]]) begin
          ghit = 1'b1;
          gidx = scan[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant       = '0;
    grant[gidx] = ghit;
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
    stream_mux_n_lane #(.WIDTH(WIDTH)) u_lane (
      .grant    (grant[i]),
      .can_load (can_load),
      .rst      (rst),
      .data     (in_data[i*WIDTH +: WIDTH]),
      .ready    (in_ready[i]),
      .data_sel (lane_data[i])
    );
  end

  // Lane data is zero unless granted, so OR-reduction yields the selected word.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_INPUTS; i++) mux_data = mux_data | lane_data[i];
  end

  // in_ready can only be set for a valid granted channel, so any ready bit
  // means a handshake completes this cycle.
  assign xfer = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_grant <= SEL_W'(N_INPUTS - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= mux_data;
      last_grant <= gidx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef STREAM_MUX_N_CHAN_TAG_EN
  always_ff @(posedge clk) begin
    if (rst)       out_chan <= '0;
    else if (xfer) out_chan <= gidx;
  end
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_ready;
`ifdef STREAM_MUX_N_CHAN_TAG_EN
  logic [1:0]  out_chan;
`endif

  always #5 clk = ~clk;

  stream_mux_n #(.N_INPUTS(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef STREAM_MUX_N_CHAN_TAG_EN
    ,
    .out_chan  (out_chan)
`endif
  );

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_last   = 3;
  logic m_ov     = 1'b0;

  // Reference grant from the current inputs and model pointer.
  task automatic model_grant(output logic hit, output int g);
    int c;
    hit = 1'b0;
    g   = 0;
    if (!mode) begin
      if (in_valid[sel]) begin hit = 1'b1; g = int'(sel); end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!hit && in_valid[c]) begin hit = 1'b1; g = c; end
      end
    end
  endtask

  // One clock: scoreboard compare of the current outputs, model update, advance.
  task automatic tick();
    logic       hit;
    int         g;
    logic       can;
    logic [3:0] er;
    #1;
    model_grant(hit, g);
    can = !m_ov || out_ready;
    er  = (hit && can && !rst) ? 4'(1 << g) : 4'b0000;
    checks++;
    if (in_ready !== er) begin
      failures++;
      $display("FAIL sb_in_ready act=%b exp=%b t=%0t", in_ready, er, $time);
    end
    if (!rst) begin
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL sb_out_valid act=%b exp=%b t=%0t", out_valid, m_ov, $time);
      end
      if (m_ov && sb.size() > 0) begin
        checks++;
        if (out_data !== sb[0].data) begin
          failures++;
          $display("FAIL sb_out_data act=%h exp=%h t=%0t", out_data, sb[0].data, $time);
        end
`ifdef STREAM_MUX_N_CHAN_TAG_EN
        checks++;
        if (out_chan !== sb[0].chan) begin
          failures++;
          $display("FAIL sb_out_chan act=%0d exp=%0d t=%0t", out_chan, sb[0].chan, $time);
        end
`endif
      end
    end
    if (rst) begin
      sb.delete();
      m_ov   = 1'b0;
      m_last = 3;
    end else begin
      if (m_ov && out_ready) begin
        void'(sb.pop_front());
        m_ov = 1'b0;
      end
      if (hit && can) begin
        sb.push_back({2'(g), in_data[g*4 +: 4]});
        m_ov   = 1'b1;
        m_last = g;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    in_data = 16'hDCBA; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL reset_out act=%b/%h exp=0/0", out_valid, out_data);
    end
`ifdef STREAM_MUX_N_CHAN_TAG_EN
    checks++;
    if (out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_chan act=%0d exp=0", out_chan);
    end
`endif
  endtask

  task automatic test_ext_sel();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ext_sel_ready act=%b exp=0100", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'hC) begin
        failures++;
        $display("FAIL ext_sel_data act=%b/%h exp=1/c", out_valid, out_data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    logic [3:0] ed;
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      er = 4'(1 << (i % 4));
      ed = 4'(10 + (i % 4));
      #1;
      checks++;
      if (in_ready !== er) begin
        failures++;
        $display("FAIL rr_ready act=%b exp=%b step=%0d", in_ready, er, i);
      end
      tick();
      checks++;
      if (out_data !== ed) begin
        failures++;
        $display("FAIL rr_data act=%h exp=%h step=%0d", out_data, ed, i);
      end
    end
  endtask

  task automatic test_skip();
    logic [3:0] er [3];
    er = '{4'b0001, 4'b1000, 4'b0001};
    mode = 1'b1; in_valid = 4'b1001; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== er[i]) begin
        failures++;
        $display("FAIL skip_ready act=%b exp=%b step=%0d", in_ready, er[i], i);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 16'h0050; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 16'h0060;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 4'h5) begin
        failures++;
        $display("FAIL stall act=%b/%b/%h exp=0000/1/5", in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL unstall_ready act=%b exp=0010", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h6) begin
      failures++;
      $display("FAIL unstall_data act=%b/%h exp=1/6", out_valid, out_data);
    end
  endtask

  task automatic test_no_grant();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0001; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL nogrant_ready act=%b exp=0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL nogrant_drain act=%b exp=0", out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_out act=%b/%h exp=0/0", out_valid, out_data);
    end
`ifdef STREAM_MUX_N_CHAN_TAG_EN
    checks++;
    if (out_chan !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_chan act=%0d exp=0", out_chan);
    end
`endif
    mode = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_first act=%b exp=0001", in_ready);
    end
    tick();
    checks++;
    if (out_data !== 4'hA) begin
      failures++;
      $display("FAIL rstmid_data act=%h exp=a", out_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = 16'h0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ext_sel();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_no_grant();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-input, W-bit stream multiplexer with valid/ready handshake on every channel and a registered output stage.
- Channel selection runs in one of two modes, chosen by a port:
  - external select, the same as a classic mux;
  - round-robin arbitration among valid inputs.
- Sits between multiple producer streams and a single consumer; it replaces trees of combinational 2:1 muxes where flow control is required.

Parameters:
- N_INPUTS, 4, number of input channels; legal range 2 to 16.
- WIDTH, 4, data width of each channel in bits.
- SEL_W, $clog2(N_INPUTS), width of the select and channel-index fields; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = external select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  N_INPUTS  per-channel valid.
- in_data  input  N_INPUTS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_INPUTS  per-channel ready; at most one bit set per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered output data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0 and out_data=0.
  - Round-robin pointer last_grant = N_INPUTS-1, so channel 0 has first priority.
  - in_ready=0 in the reset cycle.
  - Reset mid-transfer discards the held word; no handshake completes in that cycle.
- can_load = !out_valid || out_ready.
- Grant, combinational, one-hot or zero:
  - mode=0: grant channel sel if in_valid[sel]=1, otherwise no grant. Other valid channels are ignored.
  - mode=1: grant the first channel with in_valid=1 found by scanning from (last_grant+1) mod N_INPUTS upward, wrapping past N_INPUTS-1 to 0. No valid inputs means no grant.
  - sel values ≥ N_INPUTS (non-power-of-two N) produce no grant.
- in_ready[g] = can_load for the granted channel g; all other bits are 0.
- Transfer: when in_valid[g] && in_ready[g], out_data <= channel g data and out_valid <= 1 on the next edge. Latency is one cycle from input handshake to out_valid.
- Drain: when out_valid && out_ready and no new load occurs, out_valid <= 0. Load and drain in the same cycle keep out_valid=1 with the new data. This gives full throughput of 1 word/cycle.
- Stall: when out_valid && !out_ready, out_data is held stable and all in_ready bits are 0.
- last_grant updates to g only on a completed input handshake, in both modes. A mode switch therefore resumes round-robin after the last channel actually served.
- in_ready depends combinationally on out_ready. No combinational path from in_valid to out_valid.
- sel and mode may change every cycle; they take effect on the current-cycle grant.

Optional Feature:
- Macro: STREAM_MUX_N_CHAN_TAG_EN.
- When defined:
  - Extra output port out_chan, width SEL_W, registered alongside out_data.
  - Loaded with the granted index on every transfer; reset value 0.
  - Held stable while stalled.
- When undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b1111, data channels 0..3 = 4'hA,4'hB,4'hC,4'hD, out_ready=1:
  - in_ready=4'b0100;
  - next cycle out_valid=1, out_data=4'hC;
  - continuous 4'hC every cycle.
- mode=1, all four channels valid, out_ready=1 for 8 cycles:
  - out_data sequence A,B,C,D,A,B,C,D;
  - in_ready walks 0001,0010,0100,1000.
- mode=1, in_valid=4'b1001 after a grant of channel 0: next grant is channel 3, then channel 0. Channels 1 and 2 are skipped.
- Backpressure: load 4'h5 on channel 1, then hold out_ready=0 for 3 cycles:
  - out_data stays 4'h5, out_valid stays 1, in_ready=0;
  - raising out_ready drains 4'h5 and loads the next word in the same cycle.
- mode=0, sel=1, in_valid[1]=0, in_valid[0]=1: no in_ready asserted, out_valid falls to 0 after drain.
- rst asserted while out_valid=1 and out_ready=0: the next cycle out_valid=0 and out_data=0; after release, channel 0 wins first in round-robin mode. With STREAM_MUX_N_CHAN_TAG_EN, out_chan=0 after reset and matches each served index.
